// File: rtl/bus_priority_arbiter.sv
// bus_priority_arbiter: shares one resource among N requesters with bounded
// ownership. Each ownership is followed by a one-cycle GAP and one IDLE cycle.
// Optional build macro: ROUND_ROBIN_EN (rotating priority). When it is not
// defined, the arbiter uses fixed priority with the highest index winning.
module bus_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    localparam int          HCW = $clog2(MAX_HOLD + 1);
    localparam int unsigned NU  = N;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t           state;
    logic [HCW-1:0]   hold_cnt;
    logic [IDW-1:0]   pick_id;
    logic [N-1:0]     pick_oh;

`ifdef ROUND_ROBIN_EN
    logic [IDW-1:0]   last_id;
    int unsigned      rr_idx;

    // Rotating pick: scan from farthest to nearest below last_id so the
    // nearest requester (last_id-1, wrapping) is written last and wins.
    always_comb begin
        pick_id = '0;
        rr_idx  = 0;
        for (int unsigned k = NU; k >= 1; k--) begin
            rr_idx = (int unsigned'(last_id) + NU - k) % NU;
            if (req[rr_idx])
                pick_id = IDW'(rr_idx);
        end
    end
`else
    // Fixed pick: ascending scan, so the highest set index wins.
    always_comb begin
        pick_id = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (req[i])
                pick_id = IDW'(i);
        end
    end
`endif

    // One-hot form of the winner, loaded directly into grant.
    always_comb begin
        pick_oh          = '0;
        pick_oh[pick_id] = 1'b1;
    end

    // Ownership FSM with registered outputs and hold timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
`ifdef ROUND_ROBIN_EN
            last_id     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state       <= OWN;
                        grant       <= pick_oh;
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        hold_cnt    <= HCW'(1);
`ifdef ROUND_ROBIN_EN
                        last_id     <= pick_id;
`endif
                    end
                end
                OWN: begin
                    if (!req[grant_id] || hold_cnt == HCW'(MAX_HOLD)) begin
                        // Owner drop has priority: timeout only when still requesting.
                        state       <= GAP;
                        timeout     <= req[grant_id];
                        grant       <= '0;
                        grant_id    <= '0;
                        grant_valid <= 1'b0;
                        hold_cnt    <= '0;
                    end else begin
                        hold_cnt    <= hold_cnt + HCW'(1);
                    end
                end
                GAP: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_id    <= '0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_priority_arbiter.sv
// Self-checking bench for bus_priority_arbiter (N=8, MAX_HOLD=4).
// Directed scenarios plus randomized requests against a behavioural model.
module tb_bus_priority_arbiter;

    localparam int N    = 8;
    localparam int IDW  = 3;
    localparam int MAXH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           timeout;

    int total = 0;
    int bad   = 0;

    // model state: current owner (-1 none), cycles owned, remaining dead
    // cycles before arbitration may happen, timeout flag, last winner
    int m_owner, m_held, m_cool, m_last;
    bit m_to;

    bus_priority_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int last);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (((last - k) % N) + N) % N;
            if (r[c]) return c;
        end
`else
        for (int i = N - 1; i >= 0; i--)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_cool = 0; m_to = 0; m_last = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        m_to = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_cool = 1;
            end else if (m_held == MAXH) begin
                m_owner = -1; m_cool = 1; m_to = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 0) begin
            m_owner = model_pick(r, m_last);
            m_last  = m_owner;
            m_held  = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".id"}, 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    // advance one clock edge with the current req, then compare to the model
    task automatic step(input string tag);
        model_step(req);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        #1;
        check("rst.grant", 32'(grant), 32'd0);
        check("rst.valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check("por.grant", 32'(grant), 32'd0);
        check("por.id", 32'(grant_id), 32'd0);
        check("por.valid", 32'(grant_valid), 32'd0);
        check("por.timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: priority pick, one-cycle latency
        req = 8'b0000_0101;
        step("t1");
        check("t1.grant_c", 32'(grant), 32'h04);
        check("t1.id_c", 32'(grant_id), 32'd2);

        // 2: owner drops -> GAP, IDLE, then id 0
        req = 8'b0000_0001;
        step("t2.gap");
        check("t2.gap_c", 32'(grant_valid), 32'd0);
        step("t2.idle");
        check("t2.idle_c", 32'(grant_valid), 32'd0);
        step("t2.regrant");
        check("t2.id_c", 32'(grant_id), 32'd0);

        // 4: hold timer with MAX_HOLD=4
        do_reset();
        req = 8'b0000_1000;
        for (int i = 0; i < MAXH; i++) begin
            step("t4.own");
            check("t4.id_c", 32'(grant_id), 32'd3);
            check("t4.to_c", 32'(timeout), 32'd0);
        end
        step("t4.gap");
        check("t4.gapto_c", 32'(timeout), 32'd1);
        check("t4.gapv_c", 32'(grant_valid), 32'd0);
        step("t4.idle");
        check("t4.idleto_c", 32'(timeout), 32'd0);
        step("t4.regrant");
        check("t4.reid_c", 32'(grant_id), 32'd3);

        // 3: all requesting, ownerships end by timeout
        do_reset();
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            step("t3.first");
`ifdef ROUND_ROBIN_EN
            check("t3.seq_c", 32'(grant_id), 32'((7 - n + N) % N));
`else
            check("t3.seq_c", 32'(grant_id), 32'd7);
`endif
            for (int c = 0; c < MAXH + 1; c++) step("t3.hold");
        end

        // 5: no preemption
        do_reset();
        req = 8'b0000_0010;
        step("t5.g1");
        req = 8'b0010_0010;
        step("t5.hold");
        check("t5.hold_c", 32'(grant), 32'h02);
        step("t5.hold2");
        check("t5.hold2_c", 32'(grant), 32'h02);
        req = 8'b0010_0000;
        step("t5.gap");
        step("t5.idle");
        step("t5.g5");
        check("t5.id5_c", 32'(grant_id), 32'd5);

        // 6: asynchronous reset mid-ownership
        do_reset();
        req = 8'h40;
        step("t6.g6");
        check("t6.id6_c", 32'(grant_id), 32'd6);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6.arst.grant", 32'(grant), 32'd0);
        check("t6.arst.valid", 32'(grant_valid), 32'd0);
        check("t6.arst.id", 32'(grant_id), 32'd0);
        check("t6.arst.timeout", 32'(timeout), 32'd0);
        #1;
        rst = 1'b0;
        step("t6.regrant");
        check("t6.reid_c", 32'(grant_id), 32'd6);

        // randomized requests; owner usually keeps its bit up
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 4) != 0);
            req = r;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
